// File: rtl/chess_engine_pkg.sv
// Shared definitions for the chess engine bus master: command-word layout,
// FSM state encoding, piece types and the command-word builder.
package chess_engine_pkg;

    localparam int INIT_BIT  = 255;
    localparam int PT_MSB    = 254;
    localparam int PT_LSB    = 251;
    localparam int SQ_MSB    = 247;
    localparam int SQ_LSB    = 241;
    localparam int COLOR_MSB = 239;
    localparam int COLOR_LSB = 176;
    localparam int OCC_MSB   = 175;
    localparam int OCC_LSB   = 112;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SCAN  = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_READ  = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_EMIT  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    typedef enum logic [3:0] {
        PT_NONE   = 4'd0,
        PT_PAWN   = 4'd1,
        PT_KNIGHT = 4'd2,
        PT_BISHOP = 4'd3,
        PT_ROOK   = 4'd4,
        PT_QUEEN  = 4'd5,
        PT_KING   = 4'd6
    } piece_t;

    function automatic logic [255:0] build_cmd(input logic [3:0]  pt,
                                               input logic [5:0]  sq,
                                               input logic [63:0] color,
                                               input logic [63:0] occ);
        logic [255:0] c;
        c = '0;
        c[INIT_BIT]            = 1'b0;
        c[PT_MSB:PT_LSB]       = pt;
        c[SQ_MSB:SQ_LSB]       = {1'b0, sq};
        c[COLOR_MSB:COLOR_LSB] = color;
        c[OCC_MSB:OCC_LSB]     = occ;
        return c;
    endfunction

endpackage

// File: rtl/chess_engine_sweep_master_popcount64.sv
// Combinational population count of a 64-bit move bitboard.
module popcount64 (
    input  logic [63:0] din,
    output logic [6:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'b0, din[i]};
        end
    end

endmodule

// File: rtl/chess_engine_sweep_master.sv
// Bus initiator sweeping all 64 squares: for each piece of the side to move it
// writes a command word, reads back the move bitboard and accumulates results.
module chess_engine_sweep_master
    import chess_engine_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         side,
    input  logic [63:0]  occupied,
    input  logic [63:0]  color,
    input  logic [255:0] piece_types,
    output logic         busy,
    output logic         done,
    output logic         res_valid,
    output logic [5:0]   res_square,
    output logic [63:0]  res_moves,
    output logic [63:0]  attack_map,
    output logic [12:0]  move_count,
    output logic         m_chipselect,
    output logic         m_write,
    output logic         m_read,
    output logic [255:0] m_writedata,
    input  logic [255:0] m_readdata,
    input  logic         m_waitrequest
);

    localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t         state_q, state_d;
    logic [5:0]     sq_q, sq_d;
    logic [1:0]     lat_q, lat_d;
    logic           side_q, side_d;
    logic [63:0]    occ_q, occ_d;
    logic [63:0]    col_q, col_d;
    logic [255:0]   pt_q, pt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           res_valid_q, res_valid_d;
    logic [5:0]     res_square_q, res_square_d;
    logic [63:0]    res_moves_q, res_moves_d;
    logic [63:0]    attack_q, attack_d;
    logic [12:0]    count_q, count_d;
    logic           cs_q, cs_d;
    logic           wr_q, wr_d;
    logic           rd_q, rd_d;
    logic [255:0]   wdata_q, wdata_d;

    logic           sel;
    logic           capture;
    logic [63:0]    rd_moves;
    logic [6:0]     pc;
    logic           unused_rd;

    assign rd_moves  = m_readdata[63:0];
    assign unused_rd = ^m_readdata[255:64];
    assign sel       = occ_q[sq_q] & (col_q[sq_q] == side_q);

    popcount64 u_popcount (
        .din (rd_moves),
        .cnt (pc)
    );

    always_comb begin
        state_d      = state_q;
        sq_d         = sq_q;
        lat_d        = lat_q;
        side_d       = side_q;
        occ_d        = occ_q;
        col_d        = col_q;
        pt_d         = pt_q;
        res_square_d = res_square_q;
        res_moves_d  = res_moves_q;
        attack_d     = attack_q;
        count_d      = count_q;
        wdata_d      = wdata_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    sq_d     = '0;
                    side_d   = side;
                    occ_d    = occupied;
                    col_d    = color;
                    pt_d     = piece_types;
                    attack_d = '0;
                    count_d  = '0;
                end
            end
            ST_SCAN: begin
                if (sel) begin
                    state_d = ST_WRITE;
                    wdata_d = build_cmd(pt_q[{sq_q, 2'b00} +: 4], sq_q, col_q, occ_q);
                end else if (sq_q == 6'd63) begin
                    state_d = ST_DONE;
                end else begin
                    sq_d = sq_q + 6'd1;
                end
            end
            ST_WRITE: begin
                if (!m_waitrequest) state_d = ST_READ;
            end
            ST_READ: begin
                if (!m_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                // Readdata is valid on the READ_LATENCY-th cycle after acceptance.
                if (lat_q == LAT_LAST) capture = 1'b1;
                else                   lat_d   = lat_q + 2'd1;
            end
            ST_EMIT: begin
                if (sq_q == 6'd63) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                    sq_d    = sq_q + 6'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Results are registered at the capture edge so they appear during EMIT.
        if (capture) begin
            state_d      = ST_EMIT;
            res_square_d = sq_q;
            res_moves_d  = rd_moves;
            attack_d     = attack_q | rd_moves;
            count_d      = count_q + {6'b0, pc};
        end

        busy_d      = (state_d == ST_SCAN) || (state_d == ST_WRITE) || (state_d == ST_READ) ||
                      (state_d == ST_WAIT) || (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
        res_valid_d = (state_d == ST_EMIT);
        wr_d        = (state_d == ST_WRITE);
        rd_d        = (state_d == ST_READ);
        cs_d        = wr_d | rd_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sq_q         <= '0;
            lat_q        <= '0;
            side_q       <= 1'b0;
            occ_q        <= '0;
            col_q        <= '0;
            pt_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_square_q <= '0;
            res_moves_q  <= '0;
            attack_q     <= '0;
            count_q      <= '0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            sq_q         <= sq_d;
            lat_q        <= lat_d;
            side_q       <= side_d;
            occ_q        <= occ_d;
            col_q        <= col_d;
            pt_q         <= pt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_square_q <= res_square_d;
            res_moves_q  <= res_moves_d;
            attack_q     <= attack_d;
            count_q      <= count_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign res_valid    = res_valid_q;
    assign res_square   = res_square_q;
    assign res_moves    = res_moves_q;
    assign attack_map   = attack_q;
    assign move_count   = count_q;
    assign m_chipselect = cs_q;
    assign m_write      = wr_q;
    assign m_read       = rd_q;
    assign m_writedata  = wdata_q;

endmodule
